// File: rtl/mvu_seq.sv
// Sequential matrix-vector unit: one external multiply per element, one y strobe per row.
// Optional accumulator saturation is enabled with the macro MVU_SEQ_SAT_EN (wraps when undefined).
module mvu_seq #(
    parameter int BW   = 8,
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int ACCW = 20,
    parameter int WAW  = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1,
    parameter int XAW  = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [WAW-1:0]  w_addr,
    input  logic [BW-1:0]   w_data,
    output logic [XAW-1:0]  x_addr,
    input  logic [BW-1:0]   x_data,
    output logic            mul_start,
    output logic [BW-1:0]   mul_a,
    output logic [BW-1:0]   mul_b,
    input  logic [2*BW-1:0] mul_product,
    input  logic            mul_done,
    output logic            y_valid,
    output logic [RW-1:0]   y_row,
    output logic [ACCW-1:0] y_data
);

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, MUL, NEXT, WRITE, FIN
    } state_t;

    localparam logic [XAW-1:0] COL_LAST = XAW'(COLS - 1);
    localparam logic [RW-1:0]  ROW_LAST = RW'(ROWS - 1);

    state_t            state, next;
    logic [RW-1:0]     row;
    logic [XAW-1:0]    col;
    logic [ACCW-1:0]   acc;

    // Unsigned accumulate; a clamped accumulator stays clamped since products are never negative.
    function automatic logic [ACCW-1:0] acc_add(input logic [ACCW-1:0] a,
                                                input logic [2*BW-1:0] p);
        logic [ACCW:0] sum;
        sum = {1'b0, a} + (ACCW+1)'(p);
`ifdef MVU_SEQ_SAT_EN
        return sum[ACCW] ? {ACCW{1'b1}} : sum[ACCW-1:0];
`else
        return sum[ACCW-1:0];
`endif
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next      = state;
        busy      = (state != IDLE);
        done      = 1'b0;
        mul_start = 1'b0;
        y_valid   = 1'b0;
        case (state)
            IDLE:  if (start) next = FETCH;
            FETCH: next = LOAD;
            LOAD:  next = MUL;
            MUL: begin
                mul_start = 1'b1;
                if (mul_done) next = NEXT;
            end
            NEXT:  next = (col == COL_LAST) ? WRITE : FETCH;
            WRITE: begin
                y_valid = 1'b1;
                next    = (row == ROW_LAST) ? FIN : FETCH;
            end
            FIN: begin
                done = 1'b1;
                next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    // Addresses are registered on entry to FETCH so the synchronous memories return data in LOAD.
    // Row-major order means the weight address simply advances by one per element.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row    <= '0;
            col    <= '0;
            acc    <= '0;
            w_addr <= '0;
            x_addr <= '0;
            mul_a  <= '0;
            mul_b  <= '0;
            y_row  <= '0;
            y_data <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    row    <= '0;
                    col    <= '0;
                    acc    <= '0;
                    w_addr <= '0;
                    x_addr <= '0;
                end
                LOAD: begin
                    mul_a <= w_data;
                    mul_b <= x_data;
                end
                MUL: if (mul_done) acc <= acc_add(acc, mul_product);
                NEXT: begin
                    if (col != COL_LAST) begin
                        col    <= col + 1'b1;
                        x_addr <= col + 1'b1;
                        w_addr <= w_addr + 1'b1;
                    end else begin
                        y_row  <= row;
                        y_data <= acc;
                    end
                end
                WRITE: begin
                    acc <= '0;
                    col <= '0;
                    if (row != ROW_LAST) begin
                        row    <= row + 1'b1;
                        w_addr <= w_addr + 1'b1;
                        x_addr <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mvu_seq.sv
// Scoreboard bench for mvu_seq (2x2, BW=8, ACCW=16) with synchronous weight/vector memories
// and a multiplier model whose completion delay is adjustable per pass.
module tb_mvu_seq;
    localparam int BW   = 8;
    localparam int ROWS = 2;
    localparam int COLS = 2;
    localparam int ACCW = 16;
    localparam longint ACC_MAX = (64'd1 << ACCW) - 1;

    logic            clk, rst, start;
    logic            busy, done, mul_start, mul_done, y_valid;
    logic [1:0]      w_addr;
    logic [0:0]      x_addr;
    logic [BW-1:0]   w_data, x_data, mul_a, mul_b;
    logic [2*BW-1:0] mul_product;
    logic [0:0]      y_row;
    logic [ACCW-1:0] y_data;

    mvu_seq #(.BW(BW), .ROWS(ROWS), .COLS(COLS), .ACCW(ACCW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .w_addr(w_addr), .w_data(w_data), .x_addr(x_addr), .x_data(x_data),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_product(mul_product), .mul_done(mul_done),
        .y_valid(y_valid), .y_row(y_row), .y_data(y_data)
    );

    typedef struct {
        int     row;
        longint val;
    } exp_t;

    exp_t          exp_q[$];
    logic [BW-1:0] w_mem[ROWS*COLS];
    logic [BW-1:0] x_mem[COLS];
    int            mul_delay = 1;
    int            mul_cnt;
    int            tests = 0;
    int            fails = 0;
    int            done_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        w_data <= w_mem[w_addr];
        x_data <= x_mem[x_addr];
    end

    always @(posedge clk or posedge rst) begin
        if (rst)             mul_cnt <= 0;
        else if (!mul_start) mul_cnt <= 0;
        else                 mul_cnt <= mul_cnt + 1;
    end
    assign mul_done    = mul_start && (mul_cnt >= mul_delay);
    assign mul_product = mul_a * mul_b;

    function automatic void check(string name, longint act, longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    // Reference: each row is the plain dot product, then clamped or reduced modulo 2^ACCW.
    function automatic void push_model();
        for (int r = 0; r < ROWS; r++) begin
            longint s = 0;
            exp_t e;
            for (int c = 0; c < COLS; c++)
                s += longint'(w_mem[r*COLS+c]) * longint'(x_mem[c]);
`ifdef MVU_SEQ_SAT_EN
            if (s > ACC_MAX) s = ACC_MAX;
`else
            s = s % (ACC_MAX + 1);
`endif
            e.row = r;
            e.val = s;
            exp_q.push_back(e);
        end
    endfunction

    function automatic void push_const(int r, longint v);
        exp_t e;
        e.row = r;
        e.val = v;
        exp_q.push_back(e);
    endfunction

    function automatic void load_random();
        for (int i = 0; i < ROWS*COLS; i++) w_mem[i] = BW'($urandom_range(0, 255));
        for (int i = 0; i < COLS; i++)      x_mem[i] = BW'($urandom_range(0, 255));
    endfunction

    // Monitor: every result strobe is matched against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (y_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_y_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("y_row", longint'(y_row), e.row);
                    check("y_data", longint'(y_data), e.val);
                end
            end
        end
    end

    task automatic run_pass(input int d, input bit poke);
        int k;
        int dc;
        int exp_cyc;
        mul_delay = d;
        dc = done_cnt;
        exp_cyc = ROWS*(5*COLS+1) + 1 + ROWS*COLS*(d-1);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        k = 1;
        while (!done && k < 1000) begin
            @(negedge clk);
            k++;
            start = poke && (k == 6);
        end
        start = 1'b0;
        if (!done) check("pass_timeout", 0, 1);
        else       check("pass_cycles", k, exp_cyc);
        @(negedge clk);
        check("idle_after_done", {done, busy}, 0);
        check("done_count", done_cnt, dc + 1);
        check("results_drained", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        bit seen_row;
        int dc;
        rst = 1'b1;
        start = 1'b0;
        for (int i = 0; i < ROWS*COLS; i++) w_mem[i] = '0;
        for (int i = 0; i < COLS; i++) x_mem[i] = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, mul_start, y_valid, w_addr, x_addr,
                                mul_a, mul_b, y_row, y_data}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Known 2x2 example
        w_mem[0] = 8'd1; w_mem[1] = 8'd2; w_mem[2] = 8'd3; w_mem[3] = 8'd4;
        x_mem[0] = 8'd5; x_mem[1] = 8'd6;
        push_const(0, 17);
        push_const(1, 39);
        run_pass(1, 1'b0);

        // Full-scale operands overflow a 16-bit accumulator
        for (int i = 0; i < ROWS*COLS; i++) w_mem[i] = 8'hFF;
        for (int i = 0; i < COLS; i++) x_mem[i] = 8'hFF;
`ifdef MVU_SEQ_SAT_EN
        push_const(0, 65535);
        push_const(1, 65535);
`else
        push_const(0, 64514);
        push_const(1, 64514);
`endif
        run_pass(1, 1'b0);

        // Slow multiplier
        load_random(); push_model(); run_pass(3, 1'b0);
        // start pulsed while busy
        load_random(); push_model(); run_pass(1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            load_random(); push_model();
            run_pass(int'($urandom_range(1, 4)), 1'b0);
        end

        // Reset while multiplying on row 1
        load_random(); push_model();
        mul_delay = 3;
        dc = done_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        seen_row = 1'b0;
        n = 0;
        while (n < 1000) begin
            @(negedge clk);
            n++;
            if (y_valid) seen_row = 1'b1;
            if (seen_row && mul_start) break;
        end
        check("reached_row1_mul", {seen_row, mul_start}, 2'b11);
        rst = 1'b1;
        #1;
        check("abort_outputs", {busy, done, mul_start, y_valid, w_addr, x_addr,
                                mul_a, mul_b, y_row, y_data}, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("abort_no_done", done_cnt, dc);
        rst = 1'b0;
        @(negedge clk);
        load_random(); push_model(); run_pass(1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
